// File: rtl/subcells_ti_seq_pkg.sv
// Shared constants for the threshold-implemented LED datapath: nibble geometry
// and the SubCells sequencer state encoding.
package led_ti_pkg;
   localparam int NIBBLES     = 16;
   localparam int NIB_W       = 4;
   localparam int SHARE_NIB_W = 2 * NIB_W;

   typedef logic [1:0] fsm_t;
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_FIN   = 2'd3;
endpackage

// File: rtl/subcells_ti_seq_if.sv
// Handshake bus between the SubCells sequencer (master) and the masked S-box (slave).
interface subcells_ti_seq_if;
   import led_ti_pkg::*;

   logic                   sbox_start;
   logic [SHARE_NIB_W-1:0] sbox_nib;
   logic [SHARE_NIB_W-1:0] sbox_mask;
   logic [SHARE_NIB_W-1:0] sbox_q;
   logic                   sbox_done;

   modport master (output sbox_start, sbox_nib, sbox_mask, input sbox_q, sbox_done);
   modport slave  (input sbox_start, sbox_nib, sbox_mask, output sbox_q, sbox_done);
endinterface

// File: rtl/subcells_ti_seq_nibble_rw.sv
// Combinational nibble extract (at rd_idx_i) and in-place replace (at wr_idx_i)
// for one share register; idx 0 is the most significant nibble.
module nibble_rw #(
   parameter int NIBBLES = led_ti_pkg::NIBBLES,
   parameter int IDX_W   = 4
) (
   input  logic [4*NIBBLES-1:0] word_i,
   input  logic [IDX_W-1:0]     rd_idx_i,
   input  logic [IDX_W-1:0]     wr_idx_i,
   input  logic [3:0]           nib_i,
   output logic [3:0]           nib_o,
   output logic [4*NIBBLES-1:0] word_o
);
   import led_ti_pkg::*;

   int rd_pos;
   int wr_pos;

   always_comb begin
      rd_pos = NIB_W * (NIBBLES - 1 - int'(rd_idx_i));
      wr_pos = NIB_W * (NIBBLES - 1 - int'(wr_idx_i));
      nib_o  = word_i[rd_pos +: NIB_W];
      word_o = word_i;
      word_o[wr_pos +: NIB_W] = nib_i;
   end
endmodule

// File: rtl/subcells_ti_seq.sv
// Serial SubCells sequencer: walks every nibble of the two-share state through the
// external 3-share masked S-box and writes both result shares back in place.
module subcells_ti_seq #(
   parameter int NIBBLES = led_ti_pkg::NIBBLES
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               start,
   input  logic [4*NIBBLES-1:0]               state_a_i,
   input  logic [4*NIBBLES-1:0]               state_b_i,
   input  logic [led_ti_pkg::SHARE_NIB_W-1:0] rnd_i,
   output logic                               rnd_req,
   subcells_ti_seq_if.master                  sbox,
   output logic [4*NIBBLES-1:0]               state_a_o,
   output logic [4*NIBBLES-1:0]               state_b_o,
   output logic                               busy,
   output logic                               done
);
   import led_ti_pkg::*;

   localparam int W     = NIB_W * NIBBLES;
   localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   fsm_t                   st_q, st_d;
   logic [IDX_W-1:0]       idx_q, idx_d, idx_nx;
   logic [W-1:0]           a_q, a_d, b_q, b_d, a_wr, b_wr;
   logic [SHARE_NIB_W-1:0] nib_q, nib_d, mask_q, mask_d;
   logic [NIB_W-1:0]       a_rd, b_rd;
   logic                   last;

   assign idx_nx = idx_q + IDX_W'(1);
   assign last   = (idx_q == IDX_W'(NIBBLES - 1));

   // The next nibble is read from the pre-write registers; it is never the one being replaced.
   nibble_rw #(.NIBBLES(NIBBLES), .IDX_W(IDX_W)) u_rw_a (
      .word_i   (a_q),
      .rd_idx_i (idx_nx),
      .wr_idx_i (idx_q),
      .nib_i    (sbox.sbox_q[SHARE_NIB_W-1 -: NIB_W]),
      .nib_o    (a_rd),
      .word_o   (a_wr)
   );

   nibble_rw #(.NIBBLES(NIBBLES), .IDX_W(IDX_W)) u_rw_b (
      .word_i   (b_q),
      .rd_idx_i (idx_nx),
      .wr_idx_i (idx_q),
      .nib_i    (sbox.sbox_q[NIB_W-1:0]),
      .nib_o    (b_rd),
      .word_o   (b_wr)
   );

   always_comb begin
      st_d    = st_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      nib_d   = nib_q;
      mask_d  = mask_q;
      rnd_req = 1'b0;
      case (st_q)
         ST_IDLE: begin
            if (start) begin
               a_d     = state_a_i;
               b_d     = state_b_i;
               idx_d   = '0;
               nib_d   = {state_a_i[W-1 -: NIB_W], state_b_i[W-1 -: NIB_W]};
               mask_d  = rnd_i;
               rnd_req = 1'b1;
               st_d    = ST_ISSUE;
            end
         end
         ST_ISSUE: st_d = ST_WAIT;
         ST_WAIT: begin
            if (sbox.sbox_done) begin
               a_d = a_wr;
               b_d = b_wr;
               if (last) begin
                  st_d = ST_FIN;
               end else begin
                  idx_d   = idx_nx;
                  nib_d   = {a_rd, b_rd};
                  mask_d  = rnd_i;
                  rnd_req = 1'b1;
                  st_d    = ST_ISSUE;
               end
            end
         end
         default: st_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st_q   <= ST_IDLE;
         idx_q  <= '0;
         a_q    <= '0;
         b_q    <= '0;
         nib_q  <= '0;
         mask_q <= '0;
      end else begin
         st_q   <= st_d;
         idx_q  <= idx_d;
         a_q    <= a_d;
         b_q    <= b_d;
         nib_q  <= nib_d;
         mask_q <= mask_d;
      end
   end

   // S-box operands come straight from registers so they hold steady through WAIT.
   assign sbox.sbox_start = (st_q == ST_ISSUE);
   assign sbox.sbox_nib   = nib_q;
   assign sbox.sbox_mask  = mask_q;
   assign state_a_o       = a_q;
   assign state_b_o       = b_q;
   assign busy            = (st_q != ST_IDLE);
   assign done            = (st_q == ST_FIN);
endmodule

// File: tb/tb_subcells_ti_seq.sv
// Scoreboard bench for subcells_ti_seq with a behavioural masked S-box
// (done 3 cycles after start, operands sampled the cycle after start).
module tb_subcells_ti_seq;
   import led_ti_pkg::*;

   localparam logic [63:0] PT    = 64'h0123456789ABCDEF;
   localparam logic [63:0] CT    = 64'hC56B90AD3EF84712;
   localparam logic [63:0] PT2   = 64'hFEDCBA9876543210;
   localparam logic [63:0] CT2   = 64'h21748FE3DA09B65C;
   localparam logic [63:0] TBL_B = 64'h9AD71C0BBD41BDBF;

   typedef struct {
      logic [63:0] x;
      logic [63:0] b;
      int          t;
      int          rb;
      int          sb;
   } exp_t;

   logic        clk, reset, start, rnd_req, busy, done;
   logic [63:0] state_a_i, state_b_i, state_a_o, state_b_o;
   logic [7:0]  rnd_i;
   logic [7:0]  rtbl [16];
   bit          use_tbl;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   rcnt     = 0;
   int   st_cnt   = 0;
   int   done_cnt = 0;
   exp_t expq[$];

   subcells_ti_seq_if sbox_if ();

   subcells_ti_seq #(.NIBBLES(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .state_a_i (state_a_i),
      .state_b_i (state_b_i),
      .rnd_i     (rnd_i),
      .rnd_req   (rnd_req),
      .sbox      (sbox_if),
      .state_a_o (state_a_o),
      .state_b_o (state_b_o),
      .busy      (busy),
      .done      (done)
   );

   function automatic logic [3:0] sb4(input logic [3:0] x);
      logic [63:0] t;
      t = 64'hC56B90AD3EF84712;
      return t[4*(15-int'(x)) +: 4];
   endfunction

   function automatic logic [7:0] sbox_ti(input logic [7:0] nib, input logic [7:0] m);
      logic [3:0] r;
      r = m[7:4] ^ m[3:0];
      return {sb4(nib[7:4] ^ nib[3:0]) ^ r, r};
   endfunction

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   // Behavioural masked S-box sharing the block reset.
   logic [1:0] sb_cnt;
   logic [7:0] sb_q;
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         sb_cnt <= 2'd0;
         sb_q   <= 8'd0;
      end else begin
         if (sbox_if.sbox_start) sb_cnt <= 2'd1;
         else if (sb_cnt != 2'd0) sb_cnt <= sb_cnt + 2'd1;
         if (sb_cnt == 2'd1) sb_q <= sbox_ti(sbox_if.sbox_nib, sbox_if.sbox_mask);
      end
   end
   assign sbox_if.sbox_done = (sb_cnt == 2'd3);
   assign sbox_if.sbox_q    = sb_q;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // Mask source: advances one table entry after every cycle with rnd_req high.
   initial begin
      bit adv;
      adv   = 1'b0;
      rnd_i = 8'h00;
      forever begin
         @(negedge clk);
         if (adv) rcnt++;
         rnd_i = use_tbl ? rtbl[rcnt % 16] : 8'h00;
         adv   = rnd_req;
      end
   end

   // Monitor: handshake integrity every cycle, scoreboard pop on each done pulse.
   initial begin
      exp_t       e;
      bit         inflight, prev_st;
      logic [7:0] lat_nib, lat_mask;
      inflight = 1'b0;
      prev_st  = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            inflight = 1'b0;
            prev_st  = 1'b0;
            continue;
         end
         if (sbox_if.sbox_start) begin
            check("start_width", {63'd0, prev_st}, 64'd0);
            st_cnt++;
            lat_nib  = sbox_if.sbox_nib;
            lat_mask = sbox_if.sbox_mask;
            inflight = 1'b1;
         end
         if (sbox_if.sbox_done && inflight) begin
            check("nib_stable", 64'(sbox_if.sbox_nib), 64'(lat_nib));
            check("mask_stable", 64'(sbox_if.sbox_mask), 64'(lat_mask));
            inflight = 1'b0;
         end
         prev_st = sbox_if.sbox_start;
         if (done) begin
            done_cnt++;
            if (expq.size() == 0) begin
               check("unexpected_done", 64'd1, 64'd0);
            end else begin
               e = expq.pop_front();
               check("result_xor", state_a_o ^ state_b_o, e.x);
               check("result_b", state_b_o, e.b);
               check("latency", 64'(cyc - e.t), 64'd65);
               check("sbox_starts", 64'(st_cnt - e.sb), 64'd16);
               check("rnd_reqs", 64'(rcnt - e.rb), 64'd16);
            end
         end
      end
   end

   task automatic run_pass(input logic [63:0] a, input logic [63:0] b, input bit tbl,
                           input logic [63:0] exp_x, input logic [63:0] exp_b,
                           input int restart_at, input bit start_at_fin);
      exp_t e;
      int   dbase, busy_lo;
      bit   seen;
      @(posedge clk); #1;
      use_tbl   = tbl;
      state_a_i = a;
      state_b_i = b;
      start     = 1'b1;
      dbase     = done_cnt;
      e.x = exp_x; e.b = exp_b; e.t = cyc; e.rb = rcnt; e.sb = st_cnt;
      expq.push_back(e);
      busy_lo = 0;
      seen    = 1'b0;
      for (int c = 1; c <= 80 && !seen; c++) begin
         @(posedge clk); #1;
         start = (c == restart_at) || (start_at_fin && c == 65);
         @(negedge clk);
         if (c <= 65 && !busy) busy_lo++;
         seen = (done_cnt != dbase);
      end
      check("done_timeout", {63'd0, seen}, 64'd1);
      check("busy_in_pass", 64'(busy_lo), 64'd0);
      if (start_at_fin) begin
         @(posedge clk); #1;
         start = 1'b0;
         @(negedge clk);
         check("fin_start_ignored", {63'd0, busy}, 64'd0);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_a"}, state_a_o, 64'd0);
      check({tag, "_b"}, state_b_o, 64'd0);
      check({tag, "_ctl"}, {58'd0, busy, done, rnd_req, sbox_if.sbox_start, 2'b00}, 64'd0);
      check({tag, "_sbox"}, {48'd0, sbox_if.sbox_nib, sbox_if.sbox_mask}, 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
      $fatal(1, "simulation timeout");
   end

   initial begin
      rtbl = '{8'h3A, 8'h5F, 8'hC1, 8'h07, 8'h98, 8'hE2, 8'h44, 8'h6D,
               8'hB0, 8'h1C, 8'h73, 8'hFE, 8'h29, 8'h85, 8'hD6, 8'h4B};
      use_tbl   = 1'b0;
      reset     = 1'b1;
      start     = 1'b0;
      state_a_i = PT;
      state_b_i = PT2;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_zero("reset_state");
      @(posedge clk); #1;
      reset = 1'b0;

      // Zero mask, plain shares; start held during FIN must be ignored.
      run_pass(PT, 64'd0, 1'b0, CT, 64'd0, 0, 1'b1);
      // Random shares with tabled masks, then a back-to-back second vector.
      begin
         logic [63:0] ra;
         ra = {$urandom, $urandom};
         run_pass(ra, ra ^ PT, 1'b1, CT, TBL_B, 0, 1'b0);
         ra = {$urandom, $urandom};
         run_pass(ra, ra ^ PT2, 1'b1, CT2, TBL_B, 0, 1'b0);
         ra = {$urandom, $urandom};
         run_pass(ra, ra ^ PT, 1'b1, CT, TBL_B, 10, 1'b0);
      end

      // Abort a pass with reset at t+20, then run a full pass.
      @(posedge clk); #1;
      state_a_i = PT;
      state_b_i = 64'd0;
      start     = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (18) @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      check_zero("reset_mid");
      @(posedge clk); #1;
      reset = 1'b0;
      run_pass(PT2 ^ 64'h5555AAAA0F0FF0F0, 64'h5555AAAA0F0FF0F0, 1'b0, CT2, 64'd0, 0, 1'b0);

      repeat (5) @(posedge clk);
      check("queue_empty", 64'(expq.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/subcells_ti_seq.md
# subcells_ti_seq

Serial SubCells sequencer for the threshold-implemented LED datapath. Holds the 64-bit two-share cipher state and walks all 16 nibbles through the external 3-share masked S-box one at a time. For each nibble it supplies fresh 8-bit randomness, pulses the S-box start, waits for its done, and writes the two output shares back in place. It sits between the round controller (AddConstants output) and ShiftRows.

## Interface
Parameters:
- NIBBLES, 16, number of state nibbles processed; state width is 4*NIBBLES.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  reset, asynchronous, active-high.
- start  in  1  begin a SubCells pass; honoured only in IDLE.
- state_a_i  in  64  share A of the input state.
- state_b_i  in  64  share B of the input state; value = A^B.
- rnd_i  in  8  fresh mask; must be valid whenever rnd_req is high.
- rnd_req  out  1  high in a cycle where rnd_i is sampled.
- sbox_start  out  1  one-cycle start pulse to the S-box.
- sbox_nib  out  8  {A nibble, B nibble} to the S-box.
- sbox_mask  out  8  mask to the S-box.
- sbox_q  in  8  S-box result {A', B'}.
- sbox_done  in  1  S-box done.
- state_a_o  out  64  share A register.
- state_b_o  out  64  share B register.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the pass is complete.

## Operation
- FSM states: IDLE, ISSUE, WAIT, FIN.
- IDLE, start=1:
  - Capture state_a_i and state_b_i; idx<=0.
  - Load nib_r <= {A[63:60], B[63:60]}; mask_r <= rnd_i; rnd_req=1.
  - Go to ISSUE.
- ISSUE: sbox_start=1 for exactly one cycle; go to WAIT.
- WAIT: hold until sbox_done=1. On done:
  - Write sbox_q[7:4] into nibble idx of A and sbox_q[3:0] into nibble idx of B.
  - If idx==NIBBLES-1, go to FIN.
  - Otherwise idx<=idx+1, load nib_r/mask_r for the next nibble (rnd_req=1), and go to ISSUE.
- FIN: done=1; go to IDLE.
- Nibble order: idx 0 is bits [63:60]; idx 15 is bits [3:0].
- sbox_nib and sbox_mask come straight from nib_r/mask_r. They must stay stable from the ISSUE cycle until sbox_done, because the S-box samples its inputs combinationally in the cycle after start.
- No unmasking anywhere: shares are never XORed together inside this block.
- Boundary behaviour:
  - start in any state other than IDLE is ignored.
  - sbox_done outside WAIT is ignored.
  - idx does not wrap; the pass ends at NIBBLES-1.
  - start in the same cycle as FIN is ignored; a new pass needs start while in IDLE.

## Timing
- Reset values: state FSM=IDLE, idx=0, A=B=0, nib_r=mask_r=0, sbox_start=0, rnd_req=0, busy=0, done=0.
- The S-box raises done 3 cycles after sampling start, which gives 4 cycles per nibble.
- With start at cycle t:
  - ISSUE at t+1.
  - First sbox_done at t+4.
  - Last sbox_done at t+64.
  - done=1 at t+65.
- state_a_o/state_b_o hold the final result from cycle t+65 until the next start is accepted.
- Reset mid-pass: all registers return to reset values immediately. The S-box shares this reset. No partial write-back survives.

## Structure
- Shared package led_ti_pkg holds:
  - the FSM state encoding;
  - NIBBLES;
  - share-width constants (NIB_W=4, SHARE_NIB_W=8).
- The S-box is instantiated by the parent, not inside this block.
- One natural sub-module: nibble_rw, the combinational idx-based nibble extract and nibble replace for a 64-bit register, used once per share.

## Test plan
- Bench connects the real masked S-box.
- Zero mask: A=0x0123456789ABCDEF, B=0, rnd_i=0, start -> done at t+65 with A^B=0xC56B90AD3EF84712.
- Random masks and shares: A=random, B=A^0x0123456789ABCDEF, rnd_i random per request -> A^B=0xC56B90AD3EF84712, rnd_req pulsed exactly 16 times.
- Handshake: sbox_start asserted exactly 16 times, each a single cycle; sbox_nib and sbox_mask stable from each start until the matching done.
- start re-asserted at t+10 -> ignored, result and latency unchanged; busy stays high t+1..t+65.
- reset asserted at t+20 -> all outputs 0 next edge; a subsequent start completes a correct full pass.
- Back-to-back: start again one cycle after done -> second pass correct, done at 65 cycles after the second start.
